// File: rtl/toggle_counter_pkg.sv
// Shared constants for the toggle-cell based modulo counter.
package toggle_counter_pkg;

    // Default geometry: a decade counter in four bits
    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_MODULUS = 10;

    // Count direction as presented on the up input
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : toggle_counter_pkg

// File: rtl/toggle_counter_tcell.sv
// Single toggle flip-flop with synchronous load and asynchronous active-low reset.
// Holds one bit of count state; it knows nothing about counting.
module tcell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic sload,
    input  logic sdata,
    output logic q,
    output logic qbar
);

    logic state;

    // Reset clears the bit; load overrides toggle; otherwise toggle when t is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= 1'b0;
        end else if (sload) begin
            state <= sdata;
        end else if (t) begin
            state <= ~state;
        end
    end

    assign q    = state;
    assign qbar = ~state;

endmodule : tcell

// File: rtl/toggle_counter.sv
// Up/down modulo counter built from one toggle cell per bit.
// The next count is computed here and turned into per-bit toggle enables;
// the cells only store state. Load takes priority over counting and saturates
// out-of-range values to MODULUS-1.
module toggle_counter
    import toggle_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    // Largest legal count and the modulus widened so 2**WIDTH is representable
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

    dir_e             dir;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] t;

    assign dir     = dir_e'(up);
    assign at_max  = (q == MAX_COUNT);
    assign at_zero = (q == '0);

    // Terminal count: the enabled step about to roll over in the current direction
    assign tc = en & (((dir == DIR_UP) & at_max) | ((dir == DIR_DOWN) & at_zero));

    // Next count when counting; holds when disabled
    always_comb begin
        next_count = q;
        if (en) begin
            if (dir == DIR_UP) begin
                next_count = at_max ? '0 : q + 1'b1;
            end else begin
                next_count = at_zero ? MAX_COUNT : q - 1'b1;
            end
        end
    end

    // Load value clamped into the count range
    always_comb begin
        load_value = din;
        if ({1'b0, din} >= MOD_EXT) begin
            load_value = MAX_COUNT;
        end
    end

    // A bit toggles exactly where the next count differs from the current one;
    // during a load the cells ignore t and take load_value instead
    assign t = next_count ^ q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            tcell u_cell (
                .clk   (clk),
                .rst   (rst),
                .t     (t[gi]),
                .sload (load),
                .sdata (load_value[gi]),
                .q     (q[gi]),
                .qbar  (qbar[gi])
            );
        end
    endgenerate

    // One-cycle pulse after a counted roll-over; loads never produce it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc & ~load;
        end
    end

endmodule : toggle_counter
